// File: rtl/cu_pkg.sv
// cu_pkg
// Shared definitions for the control_unit microsequencer: the FSM state
// enum, opcode constants, register bank addresses, ALU operation codes and
// the packed control word driven towards memory_system.
package cu_pkg;

  localparam int OPCODE_W = 5;

  // Sixteen states fit exactly in the 4-bit state_m monitor port. LDA and
  // STA share their memory-address state because its control word is the
  // same for both; the held opcode picks the branch out of it.
  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_CLR     = 4'd1,
    S_F0      = 4'd2,
    S_F1      = 4'd3,
    S_F2      = 4'd4,
    S_DEC     = 4'd5,
    S_EX_ALU  = 4'd6,
    S_EX_INCD = 4'd7,
    S_EX_JMP  = 4'd8,
    S_EX_NOP  = 4'd9,
    S_MA      = 4'd10,
    S_LDA_MR  = 4'd11,
    S_LDA_WB  = 4'd12,
    S_STA_MD  = 4'd13,
    S_STA_WR  = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  // Opcodes. The ALU group is 00sss and is matched on its top two bits.
  localparam logic [1:0]          OP_ALU_GRP = 2'b00;
  localparam logic [OPCODE_W-1:0] OP_LDA     = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_STA     = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_INCD    = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_JMP     = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_JZ      = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_HALT    = 5'b11111;

  // Register bank addresses.
  localparam logic [2:0] REG_PC      = 3'b000;
  localparam logic [2:0] REG_DPTR    = 3'b001;
  localparam logic [2:0] REG_A       = 3'b010;
  localparam logic [2:0] REG_TEMP    = 3'b011;
  localparam logic [2:0] REG_MDR_SRC = 3'b101;
  localparam logic [2:0] REG_ACC     = 3'b111;

  // ALU operation codes.
  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_INC   = 3'b110;
  localparam logic [2:0] ALU_SHL   = 3'b111;

  // One complete control word; field names mirror the memory_system inputs.
  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busB_addr;
    logic [2:0] busC_addr;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       wr_rdn;
    logic       mdr_alu_n;
    logic       halted;
    logic       illegal_op;
  } ctrl_t;

  // True for any opcode in the 00sss ALU group.
  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return op[OPCODE_W-1 -: 2] == OP_ALU_GRP;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode
// Purely combinational half of the microsequencer. From the current state,
// the held opcode and the Z flag it produces the next state, and from that
// next state it produces the control word that will be registered alongside
// it, so the word for state S is on the outputs while state == S.
// Ports:
//   state        current FSM state
//   instruction  opcode held in IR
//   z_flag       ALU zero flag, only consulted in DEC for JZ
//   next_state   state to be entered at the next clock edge
//   ctrl_next    control word belonging to next_state
module cu_decode
  import cu_pkg::*;
#(
  parameter int         OPW       = 5,
  parameter logic [1:0] SHIFT_AMT = 2'b01
) (
  input  state_t         state,
  input  logic [OPW-1:0] instruction,
  input  logic           z_flag,
  output state_t         next_state,
  output ctrl_t          ctrl_next
);

  logic [OPCODE_W-1:0] op;
  logic [2:0]          alu_sel;

  assign op      = instruction[OPCODE_W-1:0];
  assign alu_sel = op[2:0];

  // Next-state logic. Z is sampled only here in DEC, so a not-taken JZ
  // goes through the same do-nothing execute state as an undefined opcode.
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  next_state = S_CLR;
      S_CLR:   next_state = S_F0;
      S_F0:    next_state = S_F1;
      S_F1:    next_state = S_F2;
      S_F2:    next_state = S_DEC;
      S_DEC: begin
        if (is_alu_op(op)) begin
          next_state = S_EX_ALU;
        end else begin
          case (op)
            OP_LDA,
            OP_STA:  next_state = S_MA;
            OP_INCD: next_state = S_EX_INCD;
            OP_JMP:  next_state = S_EX_JMP;
            OP_JZ:   next_state = z_flag ? S_EX_JMP : S_EX_NOP;
            OP_HALT: next_state = S_HALT;
            default: next_state = S_EX_NOP;
          endcase
        end
      end
      S_MA:      next_state = (op == OP_STA) ? S_STA_MD : S_LDA_MR;
      S_LDA_MR:  next_state = S_LDA_WB;
      S_LDA_WB:  next_state = S_F0;
      S_STA_MD:  next_state = S_STA_WR;
      S_STA_WR:  next_state = S_F0;
      S_EX_ALU,
      S_EX_INCD,
      S_EX_JMP,
      S_EX_NOP:  next_state = S_F0;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_INIT;
    endcase
  end

  // Control word for the state about to be entered; everything not named
  // in a branch stays 0.
  always_comb begin
    ctrl_next = '0;
    case (next_state)
      S_CLR: begin
        ctrl_next.ir_sclr  = 1'b1;
        ctrl_next.mar_sclr = 1'b1;
      end
      S_F0: begin
        ctrl_next.busB_addr = REG_PC;
        ctrl_next.selop     = ALU_PASSB;
        ctrl_next.mar_en    = 1'b1;
      end
      S_F1: begin
        // Memory read into MDR while PC is incremented in the same cycle.
        ctrl_next.mdr_en     = 1'b1;
        ctrl_next.mdr_alu_n  = 1'b1;
        ctrl_next.busB_addr  = REG_PC;
        ctrl_next.busC_addr  = REG_PC;
        ctrl_next.selop      = ALU_INC;
        ctrl_next.bank_wr_en = 1'b1;
      end
      S_F2: begin
        ctrl_next.ir_en = 1'b1;
      end
      S_EX_ALU: begin
        // INC is unary on ACC; every other ALU op takes A as its B operand.
        ctrl_next.busB_addr  = (alu_sel == ALU_INC) ? REG_ACC : REG_A;
        ctrl_next.busC_addr  = REG_ACC;
        ctrl_next.selop      = alu_sel;
        ctrl_next.shamt      = (alu_sel == ALU_SHL) ? SHIFT_AMT : 2'b00;
        ctrl_next.bank_wr_en = 1'b1;
        ctrl_next.enaf       = 1'b1;
      end
      S_EX_INCD: begin
        // Pointer bump; flags deliberately left untouched.
        ctrl_next.busB_addr  = REG_DPTR;
        ctrl_next.busC_addr  = REG_DPTR;
        ctrl_next.selop      = ALU_INC;
        ctrl_next.bank_wr_en = 1'b1;
      end
      S_EX_JMP: begin
        ctrl_next.busB_addr  = REG_A;
        ctrl_next.busC_addr  = REG_PC;
        ctrl_next.selop      = ALU_PASSB;
        ctrl_next.bank_wr_en = 1'b1;
      end
      S_EX_NOP: begin
        // A not-taken JZ also lands here but is a legal instruction.
        ctrl_next.illegal_op = (op != OP_JZ);
      end
      S_MA: begin
        ctrl_next.busB_addr = REG_DPTR;
        ctrl_next.selop     = ALU_PASSB;
        ctrl_next.mar_en    = 1'b1;
      end
      S_LDA_MR: begin
        ctrl_next.mdr_en    = 1'b1;
        ctrl_next.mdr_alu_n = 1'b1;
      end
      S_LDA_WB: begin
        ctrl_next.busB_addr  = REG_MDR_SRC;
        ctrl_next.busC_addr  = REG_ACC;
        ctrl_next.selop      = ALU_PASSB;
        ctrl_next.bank_wr_en = 1'b1;
      end
      S_STA_MD: begin
        ctrl_next.busB_addr = REG_ACC;
        ctrl_next.selop     = ALU_PASSB;
        ctrl_next.mdr_en    = 1'b1;
        ctrl_next.mdr_alu_n = 1'b0;
      end
      S_STA_WR: begin
        ctrl_next.wr_rdn = 1'b1;
      end
      S_HALT: begin
        ctrl_next.halted = 1'b1;
      end
      default: ctrl_next = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Fetch / decode / execute microsequencer for memory_system. Holds the state
// register and the registered control word; all decoding lives in cu_decode.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   instruction          opcode from IR
//   C, N, P, Z           ALU flags (only Z affects sequencing, via JZ)
//   ir_sclr, mar_sclr    synchronous clears of IR / MAR
//   enaf                 flag register update enable
//   selop, shamt         ALU operation and shift amount
//   bank_wr_en           register bank write enable
//   busB_addr, busC_addr register bank read / write selects
//   ir_en, mar_en, mdr_en load enables
//   wr_rdn               1 = memory write, 0 = read
//   mdr_alu_n            MDR source: 1 = memory, 0 = ALU
//   halted               high while in HALT
//   illegal_op           one-cycle pulse for an undefined opcode
//   state_m              current state, for monitoring
module control_unit
  import cu_pkg::*;
#(
  parameter int         OPW       = 5,
  parameter logic [1:0] SHIFT_AMT = 2'b01
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] instruction,
  input  logic           C,
  input  logic           N,
  input  logic           P,
  input  logic           Z,
  output logic           ir_sclr,
  output logic           mar_sclr,
  output logic           enaf,
  output logic [2:0]     selop,
  output logic [1:0]     shamt,
  output logic           bank_wr_en,
  output logic [2:0]     busB_addr,
  output logic [2:0]     busC_addr,
  output logic           ir_en,
  output logic           mar_en,
  output logic           mdr_en,
  output logic           wr_rdn,
  output logic           mdr_alu_n,
  output logic           halted,
  output logic           illegal_op,
  output logic [3:0]     state_m
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_next;
  ctrl_t  ctrl_q;

  // C, N and P are part of the flag interface but no current opcode
  // branches on them.
  logic unused_flags;
  assign unused_flags = C ^ N ^ P;

  cu_decode #(
    .OPW       (OPW),
    .SHIFT_AMT (SHIFT_AMT)
  ) u_decode (
    .state       (state),
    .instruction (instruction),
    .z_flag      (Z),
    .next_state  (next_state),
    .ctrl_next   (ctrl_next)
  );

  // State and control word advance together so outputs are glitch-free
  // registers. Reset clears the word in the same edge, which also kills a
  // pending memory write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_INIT;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_next;
    end
  end

  assign ir_sclr    = ctrl_q.ir_sclr;
  assign mar_sclr   = ctrl_q.mar_sclr;
  assign enaf       = ctrl_q.enaf;
  assign selop      = ctrl_q.selop;
  assign shamt      = ctrl_q.shamt;
  assign bank_wr_en = ctrl_q.bank_wr_en;
  assign busB_addr  = ctrl_q.busB_addr;
  assign busC_addr  = ctrl_q.busC_addr;
  assign ir_en      = ctrl_q.ir_en;
  assign mar_en     = ctrl_q.mar_en;
  assign mdr_en     = ctrl_q.mdr_en;
  assign wr_rdn     = ctrl_q.wr_rdn;
  assign mdr_alu_n  = ctrl_q.mdr_alu_n;
  assign halted     = ctrl_q.halted;
  assign illegal_op = ctrl_q.illegal_op;
  assign state_m    = state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Drives directed and random opcodes into control_unit and compares every
// cycle's control word with a per-instruction expected sequence built from
// the instruction-set description.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] instruction;
  logic       C, N, P, Z;
  logic       ir_sclr, mar_sclr, enaf;
  logic [2:0] selop;
  logic [1:0] shamt;
  logic       bank_wr_en;
  logic [2:0] busB_addr, busC_addr;
  logic       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted, illegal_op;
  logic [3:0] state_m;

  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busB;
    logic [2:0] busC;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       wr_rdn;
    logic       mdr_alu_n;
    logic       halted;
    logic       illegal_op;
  } cw_t;

  int checks_total  = 0;
  int checks_passed = 0;
  cw_t exp_q[$];

  always #5 clk = ~clk;

  control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .C           (C),
    .N           (N),
    .P           (P),
    .Z           (Z),
    .ir_sclr     (ir_sclr),
    .mar_sclr    (mar_sclr),
    .enaf        (enaf),
    .selop       (selop),
    .shamt       (shamt),
    .bank_wr_en  (bank_wr_en),
    .busB_addr   (busB_addr),
    .busC_addr   (busC_addr),
    .ir_en       (ir_en),
    .mar_en      (mar_en),
    .mdr_en      (mdr_en),
    .wr_rdn      (wr_rdn),
    .mdr_alu_n   (mdr_alu_n),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .state_m     (state_m)
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic cw_t observedWord();
    cw_t w;
    w = '{ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en, busB_addr, busC_addr,
          ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n, halted, illegal_op};
    return w;
  endfunction

  // Whole-word check plus the two mutual-exclusion invariants.
  task automatic checkWord(input string tag, input cw_t e);
    checkOutput(tag, {10'b0, observedWord()}, {10'b0, e});
    checkOutput({tag, "_inv"}, {30'b0, bank_wr_en & wr_rdn, mar_en & mdr_en}, 32'd0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: control words by meaning ----------------
  function automatic cw_t wordF0();
    cw_t w = '0;
    w.busB = 3'b000; w.selop = 3'b000; w.mar_en = 1'b1;
    return w;
  endfunction

  function automatic cw_t wordClr();
    cw_t w = '0;
    w.ir_sclr = 1'b1; w.mar_sclr = 1'b1;
    return w;
  endfunction

  // Words for every cycle after F0 of one instruction (F1 .. last EX).
  task automatic buildExpected(input logic [4:0] op, input logic z);
    cw_t w;
    exp_q.delete();
    w = '0; w.mdr_en = 1; w.mdr_alu_n = 1; w.busB = 3'b000; w.busC = 3'b000;
    w.selop = 3'b110; w.bank_wr_en = 1;
    exp_q.push_back(w);                                  // F1
    w = '0; w.ir_en = 1; exp_q.push_back(w);             // F2
    w = '0; exp_q.push_back(w);                          // DEC
    if (op[4:3] == 2'b00) begin
      w = '0; w.selop = op[2:0]; w.busC = 3'b111; w.bank_wr_en = 1; w.enaf = 1;
      w.busB  = (op[2:0] == 3'b110) ? 3'b111 : 3'b010;
      w.shamt = (op[2:0] == 3'b111) ? 2'b01 : 2'b00;
      exp_q.push_back(w);
    end else if (op == 5'b01000 || op == 5'b01001) begin
      w = '0; w.busB = 3'b001; w.mar_en = 1; exp_q.push_back(w);
      if (op == 5'b01000) begin
        w = '0; w.mdr_en = 1; w.mdr_alu_n = 1; exp_q.push_back(w);
        w = '0; w.busB = 3'b101; w.busC = 3'b111; w.bank_wr_en = 1; exp_q.push_back(w);
      end else begin
        w = '0; w.busB = 3'b111; w.mdr_en = 1; exp_q.push_back(w);
        w = '0; w.wr_rdn = 1; exp_q.push_back(w);
      end
    end else if (op == 5'b01010) begin
      w = '0; w.busB = 3'b001; w.busC = 3'b001; w.selop = 3'b110; w.bank_wr_en = 1;
      exp_q.push_back(w);
    end else if (op == 5'b01011 || (op == 5'b01100 && z)) begin
      w = '0; w.busB = 3'b010; w.busC = 3'b000; w.bank_wr_en = 1; exp_q.push_back(w);
    end else if (op == 5'b01100) begin
      w = '0; exp_q.push_back(w);
    end else if (op == 5'b11111) begin
      w = '0; w.halted = 1;
      for (int i = 0; i < 20; i++) exp_q.push_back(w);
    end else begin
      w = '0; w.illegal_op = 1; exp_q.push_back(w);
    end
  endtask

  // Called while the DUT is in F0. Checks up to 'cut' post-F0 cycles
  // (0 = all of them) and then, if the instruction completed normally,
  // the following F0.
  task automatic applyStimulus(input logic [4:0] op, input logic z, input int cut);
    int n;
    instruction = op;
    Z = z;
    C = 1'($urandom_range(0, 1));
    N = 1'($urandom_range(0, 1));
    P = 1'($urandom_range(0, 1));
    buildExpected(op, z);
    n = (cut > 0) ? cut : exp_q.size();
    for (int i = 0; i < n; i++) begin
      stepCycle();
      checkWord($sformatf("op%b_z%0d_c%0d", op, z, i + 1), exp_q[i]);
    end
    if (cut == 0 && op != 5'b11111) begin
      stepCycle();
      checkWord($sformatf("op%b_next_f0", op), wordF0());
    end
  endtask

  // Holds rst for 'edges' edges, then walks INIT -> CLR -> F0.
  task automatic resetSequence(input int edges);
    rst = 1'b1;
    for (int i = 0; i < edges; i++) begin
      stepCycle();
      checkWord($sformatf("reset_edge%0d", i), '0);
    end
    rst = 1'b0;
    stepCycle();
    checkWord("clr", wordClr());
    stepCycle();
    checkWord("f0_after_reset", wordF0());
  endtask

  initial begin
    logic [4:0] dir_ops [10];
    logic       dir_z   [10];
    logic [4:0] op;
    rst = 1'b1; instruction = '0; C = 0; N = 0; P = 0; Z = 0;
    dir_ops = '{5'b00110, 5'b00111, 5'b00001, 5'b01000, 5'b01001,
                5'b01010, 5'b01011, 5'b01100, 5'b01100, 5'b10101};
    dir_z   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    resetSequence(1);

    for (int i = 0; i < 10; i++) applyStimulus(dir_ops[i], dir_z[i], 0);

    // Reset in the STA write cycle must kill the write immediately.
    applyStimulus(5'b01001, 1'b0, 6);
    resetSequence(2);

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      applyStimulus(op, 1'($urandom_range(0, 1)), 0);
      if (op == 5'b11111) resetSequence(1);
    end

    applyStimulus(5'b11111, 1'b0, 0);
    resetSequence(1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
